gpio_arbiter: RTL and testbench

Shares one Xilinx GPIO tri-state bus (TRI_T/TRI_O/TRI_I vectors) between NUM_REQ requesters. Owners are chosen by round-robin. An owner holds the bus until it drops its request. Every ownership change inserts a forced all-tristate turnaround, so two masters never drive pins in consecutive cycles. The block sits between several bit-bang/peripheral masters and the GPIO master port that feeds the per-pin breakout.

---
 rtl/gpio_arbiter.sv | 144 ++++++++++++++
 tb/tb_gpio_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_arbiter.sv
// Round-robin owner of one shared GPIO tri-state bus. Every ownership change
// passes through an all-tristate gap so two masters never drive back to back.

module gpio_arbiter_lane #(
  parameter int W = 16
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         sel,
  input  logic [W-1:0] pin,
  output logic [W-1:0] q
);
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) q <= '0;
    else          q <= sel ? pin : '0;
  end
endmodule

module gpio_arbiter #(
  parameter int GPIO_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_REQ-1:0]               req,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [$clog2(NUM_REQ)-1:0]       owner_id,
  output logic                             busy,
  input  logic [NUM_REQ*GPIO_WIDTH-1:0]    req_t,
  input  logic [NUM_REQ*GPIO_WIDTH-1:0]    req_o,
  output logic [NUM_REQ*GPIO_WIDTH-1:0]    req_i,
  output logic [GPIO_WIDTH-1:0]            gpio_t,
  output logic [GPIO_WIDTH-1:0]            gpio_o,
  input  logic [GPIO_WIDTH-1:0]            gpio_i
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] last;
  logic [3:0]     cnt;
  logic [IDW-1:0] pick, scan;
  logic           pick_vld;
  logic           drive;

  logic [NUM_REQ-1:0][GPIO_WIDTH-1:0] t_arr, o_arr, i_arr;
  assign t_arr = req_t;
  assign o_arr = req_o;
  assign req_i = i_arr;

  assign drive = (state == GRANT) && req[owner_id];

  // Scan from last+1 upward with wrap; descending loop so the nearest hit wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    scan     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan = IDW'((int'(last) + 1 + i) % NUM_REQ);
      if (req[scan]) begin
        pick_vld = 1'b1;
        pick     = scan;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      gnt      <= '0;
      owner_id <= '0;
      busy     <= 1'b0;
      last     <= IDW'(NUM_REQ - 1);
      cnt      <= '0;
    end else begin
      case (state)
        GRANT: begin
          if (!req[owner_id]) begin
            gnt <= '0;
            if (TURNAROUND == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= TURN;
              // Counts down to zero, then arbitrates on the following edge:
              // the new grant lands TURNAROUND+1 edges after release.
              cnt   <= 4'(TURNAROUND);
            end
          end
        end
        TURN: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (pick_vld) begin
            state    <= GRANT;
            gnt      <= NUM_REQ'(1) << pick;
            owner_id <= pick;
            last     <= pick;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (pick_vld) begin
            state    <= GRANT;
            gnt      <= NUM_REQ'(1) << pick;
            owner_id <= pick;
            last     <= pick;
            busy     <= 1'b1;
          end
        end
      endcase
    end
  end

  // Pins are only driven on edges where the owner still holds its request.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gpio_t <= '1;
      gpio_o <= '0;
    end else if (drive) begin
      gpio_t <= t_arr[owner_id];
      gpio_o <= o_arr[owner_id];
    end else begin
      gpio_t <= '1;
      gpio_o <= '0;
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    gpio_arbiter_lane #(.W(GPIO_WIDTH)) u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .sel     (drive && (owner_id == IDW'(k))),
      .pin     (gpio_i),
      .q       (i_arr[k])
    );
  end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Scoreboard bench for gpio_arbiter: a TURNAROUND=1 instance (a) and a
// TURNAROUND=0 instance (b) driven by directed sequences.
module tb_gpio_arbiter;
  localparam int W = 16;
  localparam int N = 4;

  localparam int GNT_A = 0, OWN_A = 1, BUSY_A = 2, T_A = 3, O_A = 4, I_A = 5;
  localparam int GNT_B = 6, BUSY_B = 7, T_B = 8;

  logic aclk = 1'b0;
  logic aresetn;
  logic [W-1:0] gpio_i;

  logic [N-1:0] req_a, gnt_a, req_b, gnt_b;
  logic [1:0] owner_a, owner_b;
  logic busy_a, busy_b;
  logic [N*W-1:0] req_t_a, req_o_a, req_i_a, req_t_b, req_o_b, req_i_b;
  logic [W-1:0] gpio_t_a, gpio_o_a, gpio_t_b, gpio_o_b;

  logic [W-1:0] t_vals [N] = '{16'h0000, 16'h00F0, 16'h0F00, 16'hF000};
  logic [W-1:0] o_vals [N] = '{16'hA5A5, 16'h1111, 16'h2222, 16'h3333};
  logic [W-1:0] tb_vals[N] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   gq_a[$], gq_b[$], win_q[$];
  int   cyc = 0, errors = 0, checks = 0;
  logic win_en = 1'b0;
  int   run = 0;
  bit   seen_drv = 0;
  logic [N-1:0] prev_a = '0, prev_b = '0;

  gpio_arbiter #(.GPIO_WIDTH(W), .NUM_REQ(N), .TURNAROUND(1)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .req(req_a), .gnt(gnt_a), .owner_id(owner_a),
    .busy(busy_a), .req_t(req_t_a), .req_o(req_o_a), .req_i(req_i_a),
    .gpio_t(gpio_t_a), .gpio_o(gpio_o_a), .gpio_i(gpio_i)
  );

  gpio_arbiter #(.GPIO_WIDTH(W), .NUM_REQ(N), .TURNAROUND(0)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .req(req_b), .gnt(gnt_b), .owner_id(owner_b),
    .busy(busy_b), .req_t(req_t_b), .req_o(req_o_b), .req_i(req_i_b),
    .gpio_t(gpio_t_b), .gpio_o(gpio_o_b), .gpio_i(gpio_i)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] oh(int k);
    logic [63:0] v;
    v = 64'd1;
    return v << k;
  endfunction

  function automatic logic [63:0] sample(int s);
    case (s)
      GNT_A:   return 64'(gnt_a);
      OWN_A:   return 64'(owner_a);
      BUSY_A:  return 64'(busy_a);
      T_A:     return 64'(gpio_t_a);
      O_A:     return 64'(gpio_o_a);
      I_A:     return 64'(req_i_a);
      GNT_B:   return 64'(gnt_b);
      BUSY_B:  return 64'(busy_b);
      T_B:     return 64'(gpio_t_b);
      default: return '0;
    endcase
  endfunction

  task automatic exp_at(int d, int sel, logic [63:0] v, string name);
    sb.push_back(exp_t'{cyc + d, sel, v, name});
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Timestamped output checks
  always @(negedge aclk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].name, sample(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  // Grant-order monitors: every new grant must match the next queued owner
  always @(negedge aclk) begin
    if (gnt_a != '0 && prev_a == '0) begin
      if (gq_a.size() == 0) check("grant_a_unexpected", 64'(gnt_a), 64'd0);
      else begin
        int e;
        e = gq_a.pop_front();
        check("grant_order_a", 64'(owner_a), 64'(e));
        check("grant_onehot_a", 64'(gnt_a), oh(e));
      end
    end
    prev_a = gnt_a;
    if (gnt_b != '0 && prev_b == '0) begin
      if (gq_b.size() == 0) check("grant_b_unexpected", 64'(gnt_b), 64'd0);
      else begin
        int e;
        e = gq_b.pop_front();
        check("grant_order_b", 64'(owner_b), 64'(e));
      end
    end
    prev_b = gnt_b;
  end

  // All-tristate window length between two consecutive drives on instance a
  always @(negedge aclk) begin
    if (!win_en) begin
      seen_drv = 0;
      run      = 0;
    end else if (gpio_t_a == 16'hFFFF) begin
      run++;
    end else begin
      if (seen_drv && run > 0) begin
        if (win_q.size() == 0) check("ts_window_extra", 64'(run), 64'd0);
        else                   check("ts_window", 64'(run), 64'(win_q.pop_front()));
      end
      seen_drv = 1;
      run      = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0;
    req_a = '0;
    req_b = '0;
    gpio_i = 16'h1234;
    for (int k = 0; k < N; k++) begin
      req_t_a[k*W +: W] = t_vals[k];
      req_o_a[k*W +: W] = o_vals[k];
      req_t_b[k*W +: W] = tb_vals[k];
      req_o_b[k*W +: W] = ~tb_vals[k];
    end

    // Reset values
    tick(2);
    exp_at(0, GNT_A, 0, "rst_gnt");
    exp_at(0, OWN_A, 0, "rst_owner");
    exp_at(0, BUSY_A, 0, "rst_busy");
    exp_at(0, T_A, 64'hFFFF, "rst_gpio_t");
    exp_at(0, O_A, 0, "rst_gpio_o");
    exp_at(0, I_A, 0, "rst_req_i");
    exp_at(0, GNT_B, 0, "rst_gnt_b");
    exp_at(0, T_B, 64'hFFFF, "rst_gpio_t_b");
    tick(1);

    // Single owner: grant latency, pin path, req_i slice, release
    aresetn = 1'b1;
    req_a = 4'b0001;
    gq_a.push_back(0);
    exp_at(1, GNT_A, 64'h1, "p1_gnt");
    exp_at(1, OWN_A, 0, "p1_owner");
    exp_at(1, BUSY_A, 1, "p1_busy");
    exp_at(1, T_A, 64'hFFFF, "p1_gap_t");
    exp_at(2, T_A, 64'h0000, "p1_gpio_t");
    exp_at(2, O_A, 64'hA5A5, "p1_gpio_o");
    exp_at(2, I_A, 64'h1234, "p1_req_i");
    tick(2);
    gpio_i = 16'h5678;
    exp_at(1, I_A, 64'h5678, "p1_req_i2");
    tick(1);
    req_a = '0;
    exp_at(1, GNT_A, 0, "p1_rel_gnt");
    exp_at(1, T_A, 64'hFFFF, "p1_rel_t");
    exp_at(1, O_A, 0, "p1_rel_o");
    exp_at(1, I_A, 0, "p1_rel_i");
    exp_at(1, BUSY_A, 1, "p1_turn_busy");
    exp_at(2, BUSY_A, 1, "p1_turn_busy2");
    exp_at(3, BUSY_A, 0, "p1_idle_busy");
    tick(4);

    // Round robin from reset with all four requesting
    win_en = 1'b1;
    aresetn = 1'b0;
    tick(1);
    aresetn = 1'b1;
    req_a = 4'b1111;
    tick(1);
    for (int n = 0; n < 5; n++) begin
      int own;
      own = n % 4;
      gq_a.push_back(own);
      exp_at(0, GNT_A, oh(own), "rr_gnt");
      exp_at(1, T_A, 64'(t_vals[own]), "rr_gpio_t");
      exp_at(1, O_A, 64'(o_vals[own]), "rr_gpio_o");
      tick(2);
      req_a[own] = 1'b0;
      tick(1);
      exp_at(0, GNT_A, 0, "rr_rel_gnt");
      exp_at(0, T_A, 64'hFFFF, "rr_rel_t");
      if (n < 4) begin
        req_a[own] = 1'b1;
        win_q.push_back(3);
      end else begin
        req_a = '0;
      end
      tick(2);
    end
    exp_at(0, BUSY_A, 0, "rr_idle_busy");
    tick(1);
    win_en = 1'b0;

    // No preemption; after release requester 3 outranks 0 (last = 2)
    req_a = 4'b0100;
    gq_a.push_back(2);
    exp_at(1, GNT_A, 64'b0100, "np_gnt2");
    tick(2);
    req_a = 4'b1101;
    exp_at(1, GNT_A, 64'b0100, "np_hold1");
    exp_at(3, GNT_A, 64'b0100, "np_hold2");
    exp_at(3, O_A, 64'(o_vals[2]), "np_gpio_o");
    tick(3);
    req_a = 4'b1001;
    gq_a.push_back(3);
    exp_at(1, GNT_A, 0, "np_rel");
    exp_at(2, GNT_A, 0, "np_turn");
    exp_at(3, GNT_A, 64'b1000, "np_gnt3");
    exp_at(3, OWN_A, 3, "np_owner3");
    tick(4);
    req_a = 4'b0001;
    gq_a.push_back(0);
    exp_at(3, GNT_A, 64'b0001, "np_gnt0");
    tick(4);
    req_a = '0;
    tick(4);
    exp_at(0, BUSY_A, 0, "np_idle_busy");
    tick(1);

    // Short req pulse on 1 while 0 owns: lost, never granted
    req_a = 4'b0001;
    gq_a.push_back(0);
    tick(2);
    req_a = 4'b0011;
    tick(1);
    req_a = 4'b0001;
    tick(1);
    req_a = '0;
    exp_at(1, GNT_A, 0, "lost_rel");
    exp_at(3, BUSY_A, 0, "lost_idle");
    exp_at(4, GNT_A, 0, "lost_nognt");
    tick(6);

    // Asynchronous reset mid-GRANT
    req_a = 4'b0001;
    gq_a.push_back(0);
    tick(2);
    check("ar_pre_drive", 64'(gpio_t_a), 64'h0000);
    #2;
    aresetn = 1'b0;
    #1;
    check("ar_gnt", 64'(gnt_a), 0);
    check("ar_gpio_t", 64'(gpio_t_a), 64'hFFFF);
    check("ar_busy", 64'(busy_a), 0);
    check("ar_req_i", 64'(req_i_a), 0);
    req_a = 4'b0100;
    tick(1);
    aresetn = 1'b1;
    gq_a.push_back(2);
    exp_at(1, GNT_A, 64'b0100, "ar_gnt2");
    exp_at(1, OWN_A, 2, "ar_owner2");
    tick(2);
    req_a = '0;
    tick(4);

    // TURNAROUND = 0 instance: two requesters alternating
    req_b = 4'b0011;
    gq_b.push_back(0);
    exp_at(1, GNT_B, 64'b0001, "t0_gnt0");
    tick(2);
    req_b = 4'b0010;
    gq_b.push_back(1);
    exp_at(1, GNT_B, 0, "t0_rel");
    exp_at(1, BUSY_B, 0, "t0_busy_low");
    exp_at(1, T_B, 64'hFFFF, "t0_rel_t");
    exp_at(2, GNT_B, 64'b0010, "t0_gnt1");
    exp_at(2, BUSY_B, 1, "t0_busy_high");
    exp_at(2, T_B, 64'hFFFF, "t0_gap_t");
    exp_at(3, T_B, 64'(tb_vals[1]), "t0_drive1");
    tick(3);
    req_b = 4'b0001;
    gq_b.push_back(0);
    exp_at(1, GNT_B, 0, "t0_rel2");
    exp_at(1, BUSY_B, 0, "t0_busy_low2");
    exp_at(2, GNT_B, 64'b0001, "t0_gnt0b");
    exp_at(2, BUSY_B, 1, "t0_busy_high2");
    tick(2);
    req_b = '0;
    exp_at(1, BUSY_B, 0, "t0_idle");
    tick(3);

    check("sb_drained", 64'(sb.size()), 0);
    check("grants_a_drained", 64'(gq_a.size()), 0);
    check("grants_b_drained", 64'(gq_b.size()), 0);
    check("windows_drained", 64'(win_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
